// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory access path: state encoding,
// I/O window decode nibble and default bus widths.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_ISSUE = 2'd1,
        MA_WAIT  = 2'd2,
        MA_RESP  = 2'd3
    } ma_state_t;

    localparam logic [3:0] IO_BASE_NIBBLE = 4'hF;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store responder between the CPU execute step and the data BRAM.
// Optional MEM_IO_WINDOW_EN maps the top address nibble 0xF onto the io_* port.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
`ifdef MEM_IO_WINDOW_EN
    ,
    output logic [3:0]        io_addr,
    output logic              io_we,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata
`endif
);

    // Handshake: a request transfers on a posedge with req_valid && req_ready.
    // req_ready is high only in IDLE, so one request is in flight at most;
    // resp_valid is a single-cycle pulse with no ready, the requester must take it.

    generate
        if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
            $error("mem_access_unit: RD_LAT must be within 1..8");
        end
    endgenerate

    ma_state_t         state_q, state_d;
    logic [2:0]        cnt_q;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              is_io;

`ifdef MEM_IO_WINDOW_EN
    assign is_io = (lat_addr[ADDR_W-1 -: 4] == IO_BASE_NIBBLE);
`else
    assign is_io = 1'b0;
`endif

    assign resp_rdata = rdata_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            MA_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_d = MA_ISSUE;
            end
            MA_ISSUE: begin
                mem_en    = ~is_io;
                mem_we    = lat_we & ~is_io;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                // I/O accesses complete in ISSUE, so only BRAM loads wait.
                state_d   = (lat_we || is_io) ? MA_RESP : MA_WAIT;
            end
            MA_WAIT: begin
                if (cnt_q == 3'd0) state_d = MA_RESP;
            end
            MA_RESP: begin
                resp_valid = 1'b1;
                state_d    = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase
    end

`ifdef MEM_IO_WINDOW_EN
    always_comb begin
        io_addr  = '0;
        io_we    = 1'b0;
        io_wdata = '0;
        if (state_q == MA_ISSUE && is_io) begin
            io_addr  = lat_addr[3:0];
            io_we    = lat_we;
            io_wdata = lat_wdata;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MA_IDLE;
            cnt_q     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MA_IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (state_q == MA_ISSUE) begin
                cnt_q <= 3'(RD_LAT - 1);
            end else if (state_q == MA_WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (state_q == MA_WAIT && cnt_q == 3'd0) begin
                rdata_q <= mem_rdata;
            end
`ifdef MEM_IO_WINDOW_EN
            if (state_q == MA_ISSUE && is_io && !lat_we) begin
                rdata_q <= io_rdata;
            end
`endif
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side responder for the CPU controller's D-type (load/store) execute step.
- Accepts one load/store request at a time over a valid/ready handshake and drives the single-port BRAM used for data memory.
- Absorbs BRAM read latency and returns a one-cycle response pulse with load data.
- Sits between the CPU control FSM/datapath and the data BRAM.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- RD_LAT, 1, BRAM read latency in cycles; legal range 1..8; an elaboration error is raised outside that range.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load result, registered.
- busy  out  1  high in any state other than IDLE.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. The latched address, data and we registers reset to 0, and state resets to IDLE.
- States: IDLE, ISSUE, WAIT, RESP. Encoding is 2 bits.
- IDLE:
  - req_ready = 1.
  - On the posedge with req_valid = 1, latch req_we, req_addr and req_wdata, then go to ISSUE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_addr and mem_wdata come from the latched values.
  - mem_we = latched we.
  - Store: next state RESP. Load: next state WAIT and the latency counter loads RD_LAT - 1.
- WAIT (RD_LAT cycles):
  - mem_en = 0.
  - Counter decrements each cycle.
  - In the cycle where the counter is 0, resp_rdata <= mem_rdata and the next state is RESP.
- RESP (1 cycle): resp_valid = 1, then go to IDLE. The requester must take the response; there is no back-pressure.
- Latency, counting from the accept edge at the end of cycle N:
  - Store: ISSUE in N+1, resp_valid in N+2.
  - Load: resp_valid in N+2+RD_LAT.
  - Back-to-back issue rate is one request per (latency + 1) cycles, because IDLE is always revisited.
- Request-side rules:
  - req_valid outside IDLE is ignored; no queuing.
  - Request inputs may change freely after the accept edge.
- resp_rdata holds the last load value; stores and resets-free idle cycles do not alter it.
- Addresses use natural ADDR_W wrap; there is no range checking.
- Reset mid-operation:
  - Return immediately (asynchronously) to IDLE.
  - mem_en, mem_we and resp_valid drop at once.
  - An in-flight store may or may not have been committed, depending on whether the ISSUE edge occurred. No response is emitted.
- mem_* outputs and resp_valid are decoded from registered state only; there are no combinational paths from req_* to mem_*.

Optional Feature:
- Macro: MEM_IO_WINDOW_EN.
- When defined:
  - Adds ports io_addr out 4, io_we out 1, io_wdata out DATA_W, io_rdata in DATA_W.
  - Requests with latched addr[ADDR_W-1:ADDR_W-4] == 4'hF target I/O (paddles, score) and never assert mem_en.
  - In ISSUE: io_addr = addr[3:0] and io_wdata = latched data. For a store, io_we = 1 for that cycle. For a load, io_rdata is captured into resp_rdata at the end of ISSUE.
  - Both I/O loads and stores go ISSUE -> RESP, so resp_valid arrives at N+2.
- When undefined: all addresses go to BRAM and the io_* ports are absent.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - State encoding constants MA_IDLE/MA_ISSUE/MA_WAIT/MA_RESP.
  - IO_BASE_NIBBLE = 4'hF.
  - Default ADDR_W/DATA_W.
- No sub-module: the latency counter is ≤3 bits and stays inline.

Test Plan:
- Store: RD_LAT=1, req addr 0x0010, wdata 0xBEEF, we=1 -> mem_en=mem_we=1 with addr 0x0010/data 0xBEEF in N+1; resp_valid in N+2; req_ready back high in N+3.
- Load: RD_LAT=2, BRAM model returns 0x1234 at 0x0010 -> mem_en for exactly 1 cycle, resp_valid at N+4 with resp_rdata=0x1234.
- Busy ignore: issue load, hold req_valid high with addr 0x0020 during WAIT -> single BRAM access only; the second request is accepted only after returning to IDLE.
- Reset mid-load: assert reset in a WAIT cycle -> mem_en, resp_valid and busy go 0 immediately, no resp_valid pulse, req_ready=1 after release; resp_rdata=0.
- With MEM_IO_WINDOW_EN: store 0xF003 data 0x0007 -> io_we pulse with io_addr=3, io_wdata=7, mem_en never high; load 0xF001 with io_rdata=0x00AA -> resp_rdata=0x00AA at N+2.
- Wrap/back-to-back: RD_LAT=1, load 0xFFFF then store 0x0000 with req_valid held continuously -> exactly two transactions in order, with an IDLE cycle between responses.
